// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data/parity/stop framing, 3-sample majority vote,
// per-frame parity/framing flags. Define UART_RX_BREAK_DET_EN to add line-break detection (o_Break).
module uart_rx_cfg #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 o_Break,
`endif
  output logic                 o_Busy
);

  localparam int CPB  = FPGA_clk_freq / baudrate;
  localparam int HALF = (CPB - 1) / 2;
  localparam int CW   = $clog2(CPB) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  if (CPB < 8) begin : g_bad_cpb
    $error("uart_rx_cfg: FPGA_clk_freq/baudrate must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_cfg: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_WAIT_IDLE, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop0_low_q, stop0_low_d;
  logic                   dv_q, dv_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                   brk_q, brk_d;
`endif

  logic rx_s, vote, cnt_last, first_low, any_low, is_break;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  // Bit value is the majority of this cycle's and the two previous synchronised samples.
  assign vote     = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign cnt_last = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
    hist_d      = {hist_q[0], rx_s};
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_bit_d   = par_bit_q;
    stop0_low_d = stop0_low_q;
    dv_d        = 1'b0;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
`ifdef UART_RX_BREAK_DET_EN
    brk_d       = 1'b0;
`endif
    first_low   = 1'b0;
    any_low     = 1'b0;
    is_break    = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (!rx_s) begin
          clk_cnt_d = '0;
        end else if (cnt_last) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (!rx_s) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = vote ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_last) begin
          clk_cnt_d = '0;
          shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_last) begin
          clk_cnt_d = '0;
          par_bit_d = vote;
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_last) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 4'd0) stop0_low_d = ~vote;
          if (bit_cnt_q == STOP_LAST) begin
            first_low = (bit_cnt_q == 4'd0) ? ~vote : stop0_low_q;
            any_low   = first_low | ~vote;
`ifdef UART_RX_BREAK_DET_EN
            is_break  = first_low && (shreg_q == '0) && ((PARITY == 0) || !par_bit_q);
            brk_d     = is_break;
`endif
            if (!is_break) begin
              dv_d   = 1'b1;
              data_d = shreg_q;
              perr_d = (PARITY != 0) && ((^shreg_q) ^ par_bit_q ^ ODD_PAR);
              ferr_d = any_low;
            end
            // A low stop means the line may still be held low; wait for a full idle bit.
            state_d = (any_low || is_break) ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_IDLE;
      sync_q      <= '1;
      hist_q      <= '1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      stop0_low_q <= 1'b0;
      dv_q        <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_bit_q   <= par_bit_d;
      stop0_low_q <= stop0_low_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_BREAK_DET_EN
      brk_q       <= brk_d;
`endif
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Data    = data_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign o_Break      = brk_q;
`endif

endmodule
